// File: rtl/wb_sram_if.sv
// Classic Wishbone single-access bus between the AHB bridge and the SRAM slave.
// Signal names are given from the slave's point of view.
interface wb_sram_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0] adr_i;
  logic [DWIDTH-1:0] dat_i;
  logic [DWIDTH-1:0] dat_o;
  logic              cyc_i;
  logic              stb_i;
  logic              we_i;
  logic              ack_o;

  modport slave (
    input  adr_i, dat_i, cyc_i, stb_i, we_i,
    output dat_o, ack_o
  );

  modport master (
    output adr_i, dat_i, cyc_i, stb_i, we_i,
    input  dat_o, ack_o
  );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone SRAM slave with programmable wait states.
// ack_o feeds AHB hready through the bridge, so this FSM sets bus wait timing.
module wb_sram_slave #(
  parameter int AWIDTH      = 16,
  parameter int DWIDTH      = 32,
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 2
) (
  input logic       hclk,
  input logic       hresetn,
  wb_sram_if.slave  bus
);
  localparam int DEPTH = 2 ** MEM_AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  if (WAIT_STATES > 15) begin : g_bad_ws
    $error("wb_sram_slave: WAIT_STATES must be 0..15");
  end

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AWIDTH-1:0] adr_q, adr_d;
  logic [DWIDTH-1:0] wdat_q, wdat_d;
  logic              we_q, we_d;
  logic              ack_q;
  logic [DWIDTH-1:0] rdat_q, rdat_d;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              req;
  logic              enter_ack;
  logic              oor;
  logic              mem_we;
  logic [MEM_AW-1:0] idx;
  logic              unused_lsb;

  assign req = bus.cyc_i & bus.stb_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    we_d      = we_q;
    enter_ack = 1'b0;
    unique case (1'b1)
      state_q == S_WAIT: begin
        // Dropping cyc_i aborts the access, even on the final wait edge.
        if (!bus.cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d   = S_ACK;
          cnt_d     = 4'd0;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      state_q == S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        if (req) begin
          adr_d  = bus.adr_i;
          wdat_d = bus.dat_i;
          we_d   = bus.we_i;
          if (WAIT_STATES == 0) begin
            state_d   = S_ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
    endcase
  end

  // adr_d/we_d/wdat_d hold the accepted request on every ACK-entry edge.
  assign idx        = adr_d[MEM_AW+1:2];
  assign oor        = |adr_d[AWIDTH-1:MEM_AW+2];
  assign mem_we     = hresetn & enter_ack & we_d & ~oor;
  assign unused_lsb = ^adr_d[1:0];

  always_comb begin
    rdat_d = rdat_q;
    if (enter_ack && !we_d) begin
      rdat_d = oor ? '0 : mem[idx];
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_ack;
      rdat_q  <= rdat_d;
    end
  end

  always_ff @(posedge hclk) begin
    adr_q  <= adr_d;
    wdat_q <= wdat_d;
    we_q   <= we_d;
  end

  always_ff @(posedge hclk) begin
    if (mem_we) begin
      mem[idx] <= wdat_d;
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.dat_o = rdat_q;
endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: one instance with 2 wait states, one with none.
// Expected data comes from a word-array model of the memory map.
module tb_wb_sram_slave;
  logic hclk = 1'b0;
  logic hresetn = 1'b0;

  wb_sram_if #(.AWIDTH(16), .DWIDTH(32)) bus0();
  wb_sram_if #(.AWIDTH(16), .DWIDTH(32)) bus1();

  wb_sram_slave #(
    .AWIDTH(16), .DWIDTH(32), .MEM_AW(8), .WAIT_STATES(2)
  ) u_ws2 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus0.slave)
  );

  wb_sram_slave #(
    .AWIDTH(16), .DWIDTH(32), .MEM_AW(8), .WAIT_STATES(0)
  ) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus1.slave)
  );

  always #5 hclk = ~hclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m0 [256];
  logic [31:0] m1 [256];
  int          wr0 [$];
  logic [31:0] last_rd0 = '0;

  function automatic bit is_oor(input logic [15:0] a);
    return a[15:10] != 6'd0;
  endfunction

  function automatic logic [7:0] widx(input logic [15:0] a);
    return a[9:2];
  endfunction

  // One transfer on bus0; returns read data, ack latency in edges, ack on next cycle.
  task automatic xfer0(input bit we, input logic [15:0] adr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output int lat, output logic ack_nx);
    bus0.cyc_i = 1'b1;
    bus0.stb_i = 1'b1;
    bus0.we_i  = we;
    bus0.adr_i = adr;
    bus0.dat_i = wd;
    lat = -1;
    rd  = 'x;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(posedge hclk); #1;
      if (k == 1) begin
        bus0.adr_i = ~adr;
        bus0.dat_i = ~wd;
        bus0.we_i  = ~we;
      end
      if (bus0.ack_o === 1'b1) begin
        lat = k;
        rd  = bus0.dat_o;
      end
    end
    bus0.cyc_i = 1'b0;
    bus0.stb_i = 1'b0;
    @(posedge hclk); #1;
    ack_nx = bus0.ack_o;
  endtask

  task automatic xfer1_wr(input logic [15:0] adr, input logic [31:0] wd);
    bus1.cyc_i = 1'b1;
    bus1.stb_i = 1'b1;
    bus1.we_i  = 1'b1;
    bus1.adr_i = adr;
    bus1.dat_i = wd;
    @(posedge hclk); #1;
    bus1.cyc_i = 1'b0;
    bus1.stb_i = 1'b0;
    n_tests++;
    if (bus1.ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ws0_preload_ack adr=%h got=%b want=1", adr, bus1.ack_o);
    end
    @(posedge hclk); #1;
    m1[widx(adr)] = wd;
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    bus0.cyc_i = 1'b1; bus0.stb_i = 1'b1; bus0.we_i = 1'b0;
    bus0.adr_i = '0;   bus0.dat_i = '0;
    bus1.cyc_i = 1'b1; bus1.stb_i = 1'b1; bus1.we_i = 1'b0;
    bus1.adr_i = '0;   bus1.dat_i = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge hclk); #1;
      n_tests++;
      if ({bus0.ack_o, bus0.dat_o} !== 33'd0) begin
        n_fail++;
        $display("FAIL reset_ws2 ack=%b dat=%h want 0/0", bus0.ack_o, bus0.dat_o);
      end
      n_tests++;
      if ({bus1.ack_o, bus1.dat_o} !== 33'd0) begin
        n_fail++;
        $display("FAIL reset_ws0 ack=%b dat=%h want 0/0", bus1.ack_o, bus1.dat_o);
      end
    end
    bus0.cyc_i = 1'b0; bus0.stb_i = 1'b0;
    bus1.cyc_i = 1'b0; bus1.stb_i = 1'b0;
    hresetn = 1'b1;
    last_rd0 = '0;
    @(posedge hclk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd, wd;
    logic [15:0] a;
    logic        anx;
    int          lat;
    bit          we;
    xfer0(1'b1, 16'h0010, 32'hA5A5_1234, rd, lat, anx);
    m0[widx(16'h0010)] = 32'hA5A5_1234;
    wr0.push_back(int'(widx(16'h0010)));
    n_tests++;
    if (lat != 3 || anx !== 1'b0 || bus0.dat_o !== last_rd0) begin
      n_fail++;
      $display("FAIL wr_fixed lat=%0d nx=%b dat=%h want 3/0/%h",
               lat, anx, bus0.dat_o, last_rd0);
    end
    xfer0(1'b0, 16'h0010, 32'h0, rd, lat, anx);
    last_rd0 = 32'hA5A5_1234;
    n_tests++;
    if (lat != 3 || anx !== 1'b0 || rd !== 32'hA5A5_1234) begin
      n_fail++;
      $display("FAIL rd_fixed lat=%0d nx=%b dat=%h want 3/0/a5a51234",
               lat, anx, rd);
    end
    for (int i = 0; i < 16; i++) begin
      we = (i < 4) ? 1'b1 : 1'($urandom);
      wd = $urandom;
      if (we) begin
        a = {6'd0, 8'($urandom_range(1, 255)), 2'($urandom)};
        m0[widx(a)] = wd;
        wr0.push_back(int'(widx(a)));
      end else begin
        a = {6'd0, 8'(wr0[$urandom_range(0, wr0.size() - 1)]), 2'($urandom)};
      end
      xfer0(we, a, wd, rd, lat, anx);
      n_tests++;
      if (lat != 3 || anx !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_timing i=%0d lat=%0d nx=%b want 3/0", i, lat, anx);
      end
      if (!we) last_rd0 = m0[widx(a)];
      n_tests++;
      if (bus0.dat_o !== last_rd0) begin
        n_fail++;
        $display("FAIL rand_data i=%0d we=%b adr=%h got=%h want=%h",
                 i, we, a, bus0.dat_o, last_rd0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [$];
    int          pos;
    for (int i = 0; i < 4; i++) begin
      xfer1_wr(16'(4 * i), 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) seq.push_back(16'(4 * i));
    for (int i = 0; i < 6; i++) begin
      seq.push_back({14'd0, 2'($urandom)} | 16'(4 * $urandom_range(0, 3)));
    end
    pos = 0;
    bus1.cyc_i = 1'b1;
    bus1.stb_i = 1'b1;
    bus1.we_i  = 1'b0;
    bus1.adr_i = seq[0];
    for (int c = 1; c <= 2 * seq.size(); c++) begin
      @(posedge hclk); #1;
      n_tests++;
      if (bus1.ack_o !== 1'(c % 2)) begin
        n_fail++;
        $display("FAIL b2b_ack cycle=%0d got=%b want=%b", c, bus1.ack_o, 1'(c % 2));
      end
      if (bus1.ack_o === 1'b1 && pos < seq.size()) begin
        n_tests++;
        if (bus1.dat_o !== m1[widx(seq[pos])]) begin
          n_fail++;
          $display("FAIL b2b_data n=%0d adr=%h got=%h want=%h",
                   pos, seq[pos], bus1.dat_o, m1[widx(seq[pos])]);
        end
        pos++;
        if (pos < seq.size()) bus1.adr_i = seq[pos];
        else begin
          bus1.cyc_i = 1'b0;
          bus1.stb_i = 1'b0;
        end
      end
    end
    n_tests++;
    if (pos != seq.size()) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d want=%0d", pos, seq.size());
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic        anx;
    logic        seen;
    int          lat;
    xfer0(1'b1, 16'h0020, 32'h0000_0001, rd, lat, anx);
    m0[widx(16'h0020)] = 32'h1;
    for (int drop = 1; drop <= 2; drop++) begin
      seen = 1'b0;
      bus0.cyc_i = 1'b1; bus0.stb_i = 1'b1; bus0.we_i = 1'b1;
      bus0.adr_i = 16'h0020; bus0.dat_i = 32'hFFFF_FFFF;
      for (int c = 1; c <= 5; c++) begin
        @(posedge hclk); #1;
        if (c == drop) begin
          bus0.cyc_i = 1'b0;
          bus0.stb_i = (drop == 2);
        end
        seen = seen | bus0.ack_o;
      end
      bus0.stb_i = 1'b0;
      n_tests++;
      if (seen !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_ack drop=%0d got=%b want=0", drop, seen);
      end
    end
    xfer0(1'b0, 16'h0020, 32'h0, rd, lat, anx);
    last_rd0 = m0[widx(16'h0020)];
    n_tests++;
    if (rd !== 32'h0000_0001 || lat != 3) begin
      n_fail++;
      $display("FAIL abort_data got=%h lat=%0d want=00000001/3", rd, lat);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, base;
    logic [15:0] a;
    logic        anx;
    int          lat;
    base = $urandom;
    xfer0(1'b1, 16'h0000, base, rd, lat, anx);
    m0[0] = base;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 16'h0400 : {6'($urandom_range(1, 63)), 10'($urandom)};
      xfer0(1'b1, a, 32'hDEAD_BEEF, rd, lat, anx);
      n_tests++;
      if (lat != 3 || anx !== 1'b0) begin
        n_fail++;
        $display("FAIL oor_wr_ack adr=%h lat=%0d nx=%b want 3/0", a, lat, anx);
      end
      xfer0(1'b0, a, 32'h0, rd, lat, anx);
      n_tests++;
      if (rd !== (is_oor(a) ? 32'h0 : m0[widx(a)]) || lat != 3) begin
        n_fail++;
        $display("FAIL oor_rd adr=%h got=%h lat=%0d want=0/3", a, rd, lat);
      end
    end
    xfer0(1'b0, 16'h0000, 32'h0, rd, lat, anx);
    last_rd0 = m0[0];
    n_tests++;
    if (rd !== base) begin
      n_fail++;
      $display("FAIL oor_mem0 got=%h want=%h", rd, base);
    end
  endtask

  task automatic test_reset_in_ack();
    logic [31:0] rd, prior;
    logic        anx;
    int          lat;
    prior = $urandom;
    xfer0(1'b1, 16'h0030, prior, rd, lat, anx);
    m0[widx(16'h0030)] = prior;
    bus0.cyc_i = 1'b1; bus0.stb_i = 1'b1; bus0.we_i = 1'b1;
    bus0.adr_i = 16'h0030; bus0.dat_i = ~prior;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hresetn = 1'b0;
    @(posedge hclk); #1;
    n_tests++;
    if (bus0.ack_o !== 1'b0 || bus0.dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_ack ack=%b dat=%h want 0/0", bus0.ack_o, bus0.dat_o);
    end
    bus0.cyc_i = 1'b0; bus0.stb_i = 1'b0;
    hresetn = 1'b1;
    @(posedge hclk); #1;
    n_tests++;
    if (bus0.ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ack_after got=%b want=0", bus0.ack_o);
    end
    xfer0(1'b0, 16'h0030, 32'h0, rd, lat, anx);
    last_rd0 = prior;
    n_tests++;
    if (rd !== prior || lat != 3) begin
      n_fail++;
      $display("FAIL rst_word got=%h lat=%0d want=%h/3", rd, lat, prior);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_out_of_range();
    test_reset_in_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
